// File: rtl/line_window_sched.sv
// Line-buffer scheduler: writes incoming pixels into a circular NUM_LINES-row BRAM and,
// once three complete rows exist, reads back one vertical 3-pixel column per written pixel.
module line_window_sched #(
    parameter int FRAME_WIDTH  = 320,
    parameter int NUM_LINES    = 4,
    parameter int BRAM_LATENCY = 2,
    localparam int ADDR_W      = $clog2(FRAME_WIDTH * NUM_LINES)
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              data_valid_in,
    input  logic [7:0]        pixel_in,
    input  logic [10:0]       hcount_in,
    input  logic [9:0]        vcount_in,
    input  logic              frame_done_in,
    output logic [ADDR_W-1:0] wr_addr_out,
    output logic [7:0]        wr_data_out,
    output logic              wr_en_out,
    output logic [ADDR_W-1:0] rd_addr_out,
    output logic              rd_en_out,
    input  logic [7:0]        rd_data_in,
    output logic [7:0]        col_top_out,
    output logic [7:0]        col_mid_out,
    output logic [7:0]        col_bot_out,
    output logic [10:0]       col_hcount_out,
    output logic [9:0]        col_vcount_out,
    output logic              col_valid_out,
    output logic              busy_out,
    output logic              overrun_out
);

    localparam int SLOT_W = $clog2(NUM_LINES);
    localparam int CNT_W  = $clog2(BRAM_LATENCY + 3);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, EMIT} state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [SLOT_W-1:0]   wr_slot_q, wr_slot_d;
    logic [1:0]          filled_q, filled_d;
    logic [9:0]          last_v_q, last_v_d;
    logic [10:0]         req_h_q, req_h_d;
    logic [9:0]          req_v_q, req_v_d;
    logic [SLOT_W-1:0]   req_slot_q, req_slot_d;
    logic                pend_q, pend_d;
    logic [10:0]         pend_h_q, pend_h_d;
    logic [9:0]          pend_v_q, pend_v_d;
    logic [SLOT_W-1:0]   pend_slot_q, pend_slot_d;
    logic                overrun_q, overrun_d;
    logic                wr_en_q, wr_en_d;
    logic [7:0]          wr_data_q, wr_data_d;
    logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
    logic [7:0]          cap0_q, cap0_d, cap1_q, cap1_d;
    logic [7:0]          col_top_q, col_top_d, col_mid_q, col_mid_d, col_bot_q, col_bot_d;
    logic [10:0]         col_h_q, col_h_d;
    logic [9:0]          col_v_q, col_v_d;
    logic                col_valid_q, col_valid_d;
    logic [BRAM_LATENCY-1:0] tag_vld_q, tag_vld_d;
    logic [1:0]          tag_idx_q [BRAM_LATENCY];
    logic [1:0]          tag_idx_d [BRAM_LATENCY];

    logic [SLOT_W-1:0]   eff_slot, slot_new;
    logic [1:0]          eff_filled, filled_new;
    logic [9:0]          eff_last_v;
    logic                req_fire, pend_live, take_req, take_pend;
    int                  rd_slot;

    // Line tracking and write path; a coincident frame_done_in is applied before the pixel.
    always_comb begin
        eff_slot   = frame_done_in ? '0 : wr_slot_q;
        eff_filled = frame_done_in ? '0 : filled_q;
        eff_last_v = frame_done_in ? '1 : last_v_q;
        slot_new   = eff_slot;
        filled_new = eff_filled;
        if (data_valid_in && (vcount_in != eff_last_v) && (eff_last_v != '1)) begin
            slot_new = (eff_slot == SLOT_W'(NUM_LINES - 1)) ? '0 : eff_slot + 1'b1;
            if (eff_filled != 2'd3) begin
                filled_new = eff_filled + 2'd1;
            end
        end
        wr_slot_d = slot_new;
        filled_d  = filled_new;
        last_v_d  = data_valid_in ? vcount_in : eff_last_v;
        req_fire  = data_valid_in && (filled_new == 2'd3);
        wr_en_d   = data_valid_in;
        wr_data_d = data_valid_in ? pixel_in : wr_data_q;
        wr_addr_d = data_valid_in ? ADDR_W'(int'(slot_new) * FRAME_WIDTH + int'(hcount_in))
                                  : wr_addr_q;
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        req_h_d     = req_h_q;
        req_v_d     = req_v_q;
        req_slot_d  = req_slot_q;
        pend_live   = pend_q && !frame_done_in;
        pend_d      = pend_live;
        pend_h_d    = pend_h_q;
        pend_v_d    = pend_v_q;
        pend_slot_d = pend_slot_q;
        overrun_d   = frame_done_in ? 1'b0 : overrun_q;
        take_req    = 1'b0;
        take_pend   = 1'b0;
        case (state_q)
            IDLE: take_req = req_fire;
            ISSUE: begin
                if (cnt_q == CNT_W'(2)) begin
                    state_d = DRAIN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DRAIN: begin
                if (cnt_q == CNT_W'(BRAM_LATENCY - 1)) begin
                    state_d = EMIT;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            EMIT: begin
                state_d   = IDLE;
                take_pend = pend_live;
                take_req  = !pend_live && req_fire;
            end
            default: state_d = IDLE;
        endcase
        if (take_req) begin
            state_d    = ISSUE;
            cnt_d      = '0;
            req_h_d    = hcount_in;
            req_v_d    = vcount_in;
            req_slot_d = slot_new;
        end
        if (take_pend) begin
            state_d    = ISSUE;
            cnt_d      = '0;
            req_h_d    = pend_h_q;
            req_v_d    = pend_v_q;
            req_slot_d = pend_slot_q;
            pend_d     = 1'b0;
        end
        // A request the FSM cannot start now goes to the single pending slot or is lost.
        if (req_fire && !take_req) begin
            if (!pend_d) begin
                pend_d      = 1'b1;
                pend_h_d    = hcount_in;
                pend_v_d    = vcount_in;
                pend_slot_d = slot_new;
            end else begin
                overrun_d = 1'b1;
            end
        end
    end

    // Read address and return-data tagging; the tag pipe lines up with rd_data_in.
    always_comb begin
        rd_slot = int'(req_slot_q) + NUM_LINES - 3 + int'(cnt_q);
        if (rd_slot >= NUM_LINES) begin
            rd_slot = rd_slot - NUM_LINES;
        end
        rd_en_out   = (state_q == ISSUE);
        rd_addr_out = rd_en_out ? ADDR_W'(rd_slot * FRAME_WIDTH + int'(req_h_q)) : '0;
        tag_vld_d[0] = rd_en_out;
        tag_idx_d[0] = cnt_q[1:0];
        for (int i = 1; i < BRAM_LATENCY; i++) begin
            tag_vld_d[i] = tag_vld_q[i-1];
            tag_idx_d[i] = tag_idx_q[i-1];
        end
        cap0_d = cap0_q;
        cap1_d = cap1_q;
        if (tag_vld_q[BRAM_LATENCY-1] && tag_idx_q[BRAM_LATENCY-1] == 2'd0) cap0_d = rd_data_in;
        if (tag_vld_q[BRAM_LATENCY-1] && tag_idx_q[BRAM_LATENCY-1] == 2'd1) cap1_d = rd_data_in;
        col_valid_d = 1'b0;
        col_top_d   = col_top_q;
        col_mid_d   = col_mid_q;
        col_bot_d   = col_bot_q;
        col_h_d     = col_h_q;
        col_v_d     = col_v_q;
        // The bottom pixel arrives on the same edge the FSM enters EMIT.
        if (state_q == DRAIN && state_d == EMIT) begin
            col_valid_d = 1'b1;
            col_top_d   = cap0_q;
            col_mid_d   = cap1_q;
            col_bot_d   = rd_data_in;
            col_h_d     = req_h_q;
            col_v_d     = req_v_q - 10'd2;
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            wr_slot_q   <= '0;
            filled_q    <= '0;
            last_v_q    <= '1;
            req_h_q     <= '0;
            req_v_q     <= '0;
            req_slot_q  <= '0;
            pend_q      <= 1'b0;
            pend_h_q    <= '0;
            pend_v_q    <= '0;
            pend_slot_q <= '0;
            overrun_q   <= 1'b0;
            wr_en_q     <= 1'b0;
            wr_data_q   <= '0;
            wr_addr_q   <= '0;
            cap0_q      <= '0;
            cap1_q      <= '0;
            col_top_q   <= '0;
            col_mid_q   <= '0;
            col_bot_q   <= '0;
            col_h_q     <= '0;
            col_v_q     <= '0;
            col_valid_q <= 1'b0;
            tag_vld_q   <= '0;
            for (int i = 0; i < BRAM_LATENCY; i++) tag_idx_q[i] <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            wr_slot_q   <= wr_slot_d;
            filled_q    <= filled_d;
            last_v_q    <= last_v_d;
            req_h_q     <= req_h_d;
            req_v_q     <= req_v_d;
            req_slot_q  <= req_slot_d;
            pend_q      <= pend_d;
            pend_h_q    <= pend_h_d;
            pend_v_q    <= pend_v_d;
            pend_slot_q <= pend_slot_d;
            overrun_q   <= overrun_d;
            wr_en_q     <= wr_en_d;
            wr_data_q   <= wr_data_d;
            wr_addr_q   <= wr_addr_d;
            cap0_q      <= cap0_d;
            cap1_q      <= cap1_d;
            col_top_q   <= col_top_d;
            col_mid_q   <= col_mid_d;
            col_bot_q   <= col_bot_d;
            col_h_q     <= col_h_d;
            col_v_q     <= col_v_d;
            col_valid_q <= col_valid_d;
            tag_vld_q   <= tag_vld_d;
            for (int i = 0; i < BRAM_LATENCY; i++) tag_idx_q[i] <= tag_idx_d[i];
        end
    end

    assign wr_en_out      = wr_en_q;
    assign wr_data_out    = wr_data_q;
    assign wr_addr_out    = wr_addr_q;
    assign col_top_out    = col_top_q;
    assign col_mid_out    = col_mid_q;
    assign col_bot_out    = col_bot_q;
    assign col_hcount_out = col_h_q;
    assign col_vcount_out = col_v_q;
    assign col_valid_out  = col_valid_q;
    assign busy_out       = (state_q != IDLE);
    assign overrun_out    = overrun_q;

endmodule

// File: tb/tb_line_window_sched.sv
// Scoreboard bench for line_window_sched: directed pixels push expected writes, reads and
// columns into queues; a negedge monitor pops and compares whenever the DUT strobes.
module tb_line_window_sched;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        data_valid_in, frame_done_in;
    logic [7:0]  pixel_in;
    logic [10:0] hcount_in;
    logic [9:0]  vcount_in;
    logic [10:0] wr_addr_out, rd_addr_out;
    logic [7:0]  wr_data_out, rd_data_in;
    logic        wr_en_out, rd_en_out;
    logic [7:0]  col_top_out, col_mid_out, col_bot_out;
    logic [10:0] col_hcount_out;
    logic [9:0]  col_vcount_out;
    logic        col_valid_out, busy_out, overrun_out;

    typedef struct {
        int a; int b; int c; int d; int e; int cyc;
    } ent_t;

    ent_t wr_q[$];
    ent_t rd_q[$];
    ent_t col_q[$];
    ent_t mon_e;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int c0;

    logic [7:0] mem [0:2047];
    logic [7:0] bram_p1;

    line_window_sched dut (
        .clk_in(clk_in), .rst_in(rst_in), .data_valid_in(data_valid_in),
        .pixel_in(pixel_in), .hcount_in(hcount_in), .vcount_in(vcount_in),
        .frame_done_in(frame_done_in), .wr_addr_out(wr_addr_out),
        .wr_data_out(wr_data_out), .wr_en_out(wr_en_out), .rd_addr_out(rd_addr_out),
        .rd_en_out(rd_en_out), .rd_data_in(rd_data_in), .col_top_out(col_top_out),
        .col_mid_out(col_mid_out), .col_bot_out(col_bot_out),
        .col_hcount_out(col_hcount_out), .col_vcount_out(col_vcount_out),
        .col_valid_out(col_valid_out), .busy_out(busy_out), .overrun_out(overrun_out)
    );

    always #5 clk_in = ~clk_in;
    always @(posedge clk_in) cyc <= cyc + 1;

    // Read-first BRAM with two cycles of read latency.
    initial begin
        for (int i = 0; i < 2048; i++) mem[i] = 8'h00;
        bram_p1 = 8'h00;
        rd_data_in = 8'h00;
    end
    always @(posedge clk_in) begin
        if (wr_en_out) mem[wr_addr_out] <= wr_data_out;
        if (rd_en_out) bram_p1 <= mem[rd_addr_out];
        rd_data_in <= bram_p1;
    end

    function automatic int pf(input int v, input int h);
        return (v * 37 + h * 11 + 3) % 256;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk_in) begin
        if (wr_en_out) begin
            if (wr_q.size() == 0) chk("unexpected_write", int'(wr_addr_out), -1);
            else begin
                mon_e = wr_q.pop_front();
                chk("wr_addr", int'(wr_addr_out), mon_e.a);
                chk("wr_data", int'(wr_data_out), mon_e.b);
                chk("wr_cycle", cyc, mon_e.cyc);
            end
        end
        if (rd_en_out) begin
            if (rd_q.size() == 0) chk("unexpected_read", int'(rd_addr_out), -1);
            else begin
                mon_e = rd_q.pop_front();
                chk("rd_addr", int'(rd_addr_out), mon_e.a);
                chk("rd_cycle", cyc, mon_e.cyc);
            end
        end
        if (col_valid_out) begin
            $display("col h=%0d v=%0d top=%0d mid=%0d bot=%0d cycle=%0d", col_hcount_out,
                     col_vcount_out, col_top_out, col_mid_out, col_bot_out, cyc);
            if (col_q.size() == 0) chk("unexpected_col", int'(col_hcount_out), -1);
            else begin
                mon_e = col_q.pop_front();
                chk("col_top", int'(col_top_out), mon_e.a);
                chk("col_mid", int'(col_mid_out), mon_e.b);
                chk("col_bot", int'(col_bot_out), mon_e.c);
                chk("col_hcount", int'(col_hcount_out), mon_e.d);
                chk("col_vcount", int'(col_vcount_out), mon_e.e);
                chk("col_cycle", cyc, mon_e.cyc);
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk_in);
            #1;
        end
    endtask

    task automatic pix(input int v, input int h, input int addr, input bit fd, output int c);
        c = cyc;
        data_valid_in = 1'b1;
        frame_done_in = fd;
        pixel_in  = 8'(pf(v, h));
        hcount_in = 11'(h);
        vcount_in = 10'(v);
        wr_q.push_back('{a: addr, b: pf(v, h), c: 0, d: 0, e: 0, cyc: c + 1});
        @(posedge clk_in);
        #1;
        data_valid_in = 1'b0;
        frame_done_in = 1'b0;
    endtask

    task automatic exp_rd(input int a0, input int a1, input int a2, input int c);
        rd_q.push_back('{a: a0, b: 0, c: 0, d: 0, e: 0, cyc: c});
        rd_q.push_back('{a: a1, b: 0, c: 0, d: 0, e: 0, cyc: c + 1});
        rd_q.push_back('{a: a2, b: 0, c: 0, d: 0, e: 0, cyc: c + 2});
    endtask

    task automatic exp_col(input int t, input int m, input int b, input int h, input int v,
                           input int c);
        col_q.push_back('{a: t, b: m, c: b, d: h, e: v, cyc: c});
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_wr_en"}, int'(wr_en_out), 0);
        chk({tag, "_wr_addr"}, int'(wr_addr_out), 0);
        chk({tag, "_wr_data"}, int'(wr_data_out), 0);
        chk({tag, "_rd_en"}, int'(rd_en_out), 0);
        chk({tag, "_rd_addr"}, int'(rd_addr_out), 0);
        chk({tag, "_col_valid"}, int'(col_valid_out), 0);
        chk({tag, "_col_data"}, int'({col_top_out, col_mid_out, col_bot_out}), 0);
        chk({tag, "_col_pos"}, int'({col_hcount_out, col_vcount_out}), 0);
        chk({tag, "_busy"}, int'(busy_out), 0);
        chk({tag, "_overrun"}, int'(overrun_out), 0);
    endtask

    initial begin
        int hl [5];
        int budget;
        hl = '{5, 0, 1, 2, 3};
        rst_in = 1'b1;
        data_valid_in = 1'b0;
        frame_done_in = 1'b0;
        pixel_in = '0;
        hcount_in = '0;
        vcount_in = '0;
        #1 rst_in = 1'b0;
        idle(3);
        chk_zero("reset");
        rst_in = 1'b1;
        idle(10);

        // Fill three rows: writes only, no reads or columns.
        for (int v = 0; v < 3; v++) begin
            for (int h = 0; h < 320; h++) begin
                pix(v, h, v * 320 + h, 1'b0, c0);
                idle(7);
            end
        end

        // First complete window, row 3.
        foreach (hl[i]) begin
            pix(3, hl[i], 960 + hl[i], 1'b0, c0);
            exp_rd(hl[i], 320 + hl[i], 640 + hl[i], c0 + 1);
            exp_col(pf(0, hl[i]), pf(1, hl[i]), pf(2, hl[i]), hl[i], 1, c0 + 6);
            if (i == 0) chk("busy_after_request", int'(busy_out), 1);
            idle(7);
        end

        // Slot wrap: row 4 lands in slot 0.
        pix(4, 0, 0, 1'b0, c0);
        exp_rd(320, 640, 960, c0 + 1);
        exp_col(pf(1, 0), pf(2, 0), pf(3, 0), 0, 2, c0 + 6);
        idle(7);

        // Burst at cycles 0, 2, 3: second queued, third dropped.
        c0 = cyc;
        pix(4, 1, 1, 1'b0, c0);
        exp_rd(321, 641, 961, c0 + 1);
        exp_col(pf(1, 1), pf(2, 1), pf(3, 1), 1, 2, c0 + 6);
        idle(1);
        pix(4, 2, 2, 1'b0, budget);
        exp_rd(322, 642, 962, c0 + 7);
        exp_col(pf(1, 2), pf(2, 2), pf(3, 2), 2, 2, c0 + 12);
        pix(4, 3, 3, 1'b0, budget);
        chk("overrun_set", int'(overrun_out), 1);
        idle(20);
        chk("overrun_sticky", int'(overrun_out), 1);
        chk("busy_idle", int'(busy_out), 0);

        // Row 5 moves to slot 1; window spans slots 2, 3, 0.
        pix(5, 2, 322, 1'b0, c0);
        exp_rd(642, 962, 2, c0 + 1);
        exp_col(pf(2, 2), pf(3, 2), pf(4, 2), 2, 3, c0 + 6);
        idle(10);

        // Frame restart: slot 0, no window until the fourth row.
        frame_done_in = 1'b1;
        idle(1);
        frame_done_in = 1'b0;
        chk("overrun_cleared", int'(overrun_out), 0);
        pix(5, 9, 9, 1'b0, c0);
        idle(7);
        pix(6, 9, 329, 1'b0, c0);
        idle(7);
        pix(7, 9, 649, 1'b0, c0);
        idle(7);
        pix(8, 9, 969, 1'b0, c0);
        exp_rd(9, 329, 649, c0 + 1);
        exp_col(pf(5, 9), pf(6, 9), pf(7, 9), 9, 6, c0 + 6);
        idle(9);

        // Reset asserted at cycle 4 of a sequence: reads happen, no column.
        pix(8, 10, 970, 1'b0, c0);
        exp_rd(10, 330, 650, c0 + 1);
        idle(3);
        rst_in = 1'b0;
        #2;
        chk_zero("midreset");
        idle(2);
        rst_in = 1'b1;
        idle(10);

        // frame_done with a pixel in the same cycle: pixel becomes row 0, slot 0.
        pix(20, 3, 3, 1'b0, c0);
        idle(7);
        pix(21, 3, 323, 1'b0, c0);
        idle(7);
        pix(21, 6, 6, 1'b1, c0);
        idle(7);
        pix(22, 6, 326, 1'b0, c0);
        idle(7);
        pix(23, 6, 646, 1'b0, c0);
        idle(7);
        pix(24, 6, 966, 1'b0, c0);
        exp_rd(6, 326, 646, c0 + 1);
        exp_col(pf(21, 6), pf(22, 6), pf(23, 6), 6, 22, c0 + 6);

        budget = 0;
        while ((wr_q.size() + rd_q.size() + col_q.size() != 0 || busy_out) && budget < 100) begin
            idle(1);
            budget++;
        end
        idle(5);
        chk("outstanding_expectations", wr_q.size() + rd_q.size() + col_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
